// File: rtl/pc_sequencer.sv
// Program-flow controller: PC, conditional branches, load wait cycle and start/done handshake.
// Optional performance counters are built when PC_PERF_CNT_EN is defined.
module pc_sequencer #(
    parameter int             PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] START_ADDR = '0,
    parameter logic [8:0]     HALT_INSTR = 9'h1FF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [8:0]          instr,
    input  logic                abs_branch,
    input  logic                rel_branch,
    input  logic                branch_flag,
    input  logic                branch_invert,
    input  logic                mem_to_reg,
    input  logic                zero_flag,
    input  logic                neg_flag,
    input  logic [PC_WIDTH-1:0] abs_target,
    input  logic [5:0]          rel_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                commit,
    output logic                done
`ifdef PC_PERF_CNT_EN
    ,
    output logic [15:0]         cycle_cnt,
    output logic [15:0]         instr_cnt
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_LOAD_WAIT = 2'd2;
    localparam logic [1:0] S_HALTED    = 2'd3;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                done_q, done_d;

    logic                flag;
    logic                taken;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_rel;

    assign flag   = branch_flag ? neg_flag : zero_flag;
    assign taken  = (abs_branch | rel_branch) & (flag ^ branch_invert);
    assign pc_inc = pc_q + PC_ONE;
    // Offset is sign-extended so backward branches wrap modulo 2^PC_WIDTH.
    assign pc_rel = pc_q + {{(PC_WIDTH-6){rel_offset[5]}}, rel_offset};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                end
            end
            S_RUN: begin
                // Halt is checked first so its decode fields never matter.
                if (instr == HALT_INSTR) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (mem_to_reg) begin
                    state_d = S_LOAD_WAIT;
                end else begin
                    commit = 1'b1;
                    if (taken && abs_branch)
                        pc_d = abs_target;
                    else if (taken && rel_branch)
                        pc_d = pc_rel;
                    else
                        pc_d = pc_inc;
                end
            end
            S_LOAD_WAIT: begin
                commit  = 1'b1;
                pc_d    = pc_inc;
                state_d = S_RUN;
            end
            S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    assign pc   = pc_q;
    assign done = done_q;

`ifdef PC_PERF_CNT_EN
    logic [15:0] cycle_cnt_q;
    logic [15:0] instr_cnt_q;
    logic        start_accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (start_accept) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if ((state_q == S_RUN) || (state_q == S_LOAD_WAIT))
                cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (commit)
                instr_cnt_q <= sat_inc(instr_cnt_q);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed program scenarios plus randomized
// stimulus against a program-level reference model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [8:0] instr;
    logic       abs_branch, rel_branch, branch_flag, branch_invert;
    logic       mem_to_reg, zero_flag, neg_flag;
    logic [9:0] abs_target;
    logic [5:0] rel_offset;
    logic [9:0] pc;
    logic       commit, done;
`ifdef PC_PERF_CNT_EN
    logic [15:0] cycle_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 executing, 2 second cycle of a load, 3 halted
    int m_mode, m_pc, m_done, m_cyc, m_ins;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .instr        (instr),
        .abs_branch   (abs_branch),
        .rel_branch   (rel_branch),
        .branch_flag  (branch_flag),
        .branch_invert(branch_invert),
        .mem_to_reg   (mem_to_reg),
        .zero_flag    (zero_flag),
        .neg_flag     (neg_flag),
        .abs_target   (abs_target),
        .rel_offset   (rel_offset),
        .pc           (pc),
        .commit       (commit),
        .done         (done)
`ifdef PC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_commit();
        if (m_mode == 2) return 1;
        if (m_mode == 1 && instr != 9'h1FF && !mem_to_reg) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_done = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic clear_inputs();
        start = 0; instr = 9'h000; abs_branch = 0; rel_branch = 0;
        branch_flag = 0; branch_invert = 0; mem_to_reg = 0;
        zero_flag = 0; neg_flag = 0; abs_target = '0; rel_offset = '0;
    endtask

    // Called at a falling edge with inputs already driven: compare, advance model, clock.
    task automatic tick();
        int c, flag, off, nmode, npc, ndone, ncyc, nins;
        #1;
        c = m_commit();
        chk("pc", int'(pc), m_pc);
        chk("done", int'(done), m_done);
        chk("commit", int'(commit), c);
`ifdef PC_PERF_CNT_EN
        chk("cycle_cnt", int'(cycle_cnt), m_cyc);
        chk("instr_cnt", int'(instr_cnt), m_ins);
`endif
        nmode = m_mode; npc = m_pc; ndone = m_done;
        ncyc = m_cyc; nins = m_ins;
        if (m_mode == 1 || m_mode == 2) ncyc = sat(m_cyc);
        if (c == 1) nins = sat(m_ins);
        case (m_mode)
            0, 3: if (start) begin
                nmode = 1; npc = 0; ndone = 0; ncyc = 0; nins = 0;
            end
            1: begin
                if (instr == 9'h1FF) begin
                    nmode = 3; ndone = 1;
                end else if (mem_to_reg) begin
                    nmode = 2;
                end else begin
                    flag = branch_flag ? int'(neg_flag) : int'(zero_flag);
                    off  = rel_offset[5] ? int'(rel_offset) - 64 : int'(rel_offset);
                    if (abs_branch && (flag != int'(branch_invert)))
                        npc = int'(abs_target);
                    else if (rel_branch && (flag != int'(branch_invert)))
                        npc = (m_pc + off) & 32'h3FF;
                    else
                        npc = (m_pc + 1) % 1024;
                end
            end
            default: begin
                nmode = 1; npc = (m_pc + 1) % 1024;
            end
        endcase
        @(posedge clk);
        m_mode = nmode; m_pc = npc; m_done = ndone; m_cyc = ncyc; m_ins = nins;
        @(negedge clk);
    endtask

    task automatic alu(input logic [8:0] ins);
        clear_inputs();
        instr = ins;
        tick();
    endtask

    task automatic jump_abs(input logic [9:0] tgt);
        clear_inputs();
        instr = 9'h040; abs_branch = 1; zero_flag = 1; abs_target = tgt;
        tick();
    endtask

    task automatic async_reset_check(input string tag);
        reset_n = 0;
        #1;
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_commit"}, int'(commit), 0);
        chk({tag, "_done"}, int'(done), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_commit", int'(commit), 0);
        reset_n = 1;
        @(negedge clk);

        // Three-instruction program: ADD, XOR, HALT
        clear_inputs(); start = 1; tick();
        chk("prog_pc0", int'(pc), 0);
        clear_inputs(); instr = 9'h012; #1 chk("prog_commit0", int'(commit), 1); tick();
        chk("prog_pc1", int'(pc), 1);
        clear_inputs(); instr = 9'h0A5; #1 chk("prog_commit1", int'(commit), 1); tick();
        chk("prog_pc2", int'(pc), 2);
        clear_inputs(); instr = 9'h1FF; #1 chk("prog_commit2", int'(commit), 0); tick();
        chk("prog_done", int'(done), 1);
        chk("prog_pc_hold", int'(pc), 2);

        // Restart, jump to 4, load there
        clear_inputs(); start = 1; tick();
        chk("restart_done", int'(done), 0);
        jump_abs(10'd4);
        chk("abs_pc4", int'(pc), 4);
        clear_inputs(); instr = 9'h0C8; mem_to_reg = 1; #1 chk("load_commit0", int'(commit), 0); tick();
        chk("load_pc_hold", int'(pc), 4);
        #1 chk("load_commit1", int'(commit), 1); tick();
        chk("load_pc5", int'(pc), 5);

        // Relative branch from 10, offset -3, taken and inverted
        jump_abs(10'd10);
        clear_inputs(); instr = 9'h080; rel_branch = 1; rel_offset = 6'h3D; zero_flag = 1; tick();
        chk("rel_back_pc7", int'(pc), 7);
        jump_abs(10'd10);
        clear_inputs(); instr = 9'h080; rel_branch = 1; rel_offset = 6'h3D; zero_flag = 1;
        branch_invert = 1; tick();
        chk("rel_inv_pc11", int'(pc), 11);

        // Absolute on negative flag, then forward wrap
        clear_inputs(); instr = 9'h048; abs_branch = 1; branch_flag = 1; neg_flag = 1;
        abs_target = 10'h3F0; tick();
        chk("abs_neg_pc", int'(pc), 10'h3F0);
        clear_inputs(); instr = 9'h080; rel_branch = 1; rel_offset = 6'd31; zero_flag = 1; tick();
        chk("rel_wrap_pc", int'(pc), 10'h00F);

        // start while running is ignored
        clear_inputs(); instr = 9'h012; start = 1; tick();
        chk("start_ignored_pc", int'(pc), 10'h010);

        // Reset during the second cycle of a load
        clear_inputs(); instr = 9'h0C8; mem_to_reg = 1; tick();
        #1 chk("lw_commit_before_rst", int'(commit), 1);
        async_reset_check("lw_rst");

`ifdef PC_PERF_CNT_EN
        clear_inputs(); start = 1; tick();
        alu(9'h011); alu(9'h022); alu(9'h033);
        clear_inputs(); instr = 9'h0C8; mem_to_reg = 1; tick(); tick();
        alu(9'h1FF);
        chk("perf_cycles", int'(cycle_cnt), 6);
        chk("perf_instrs", int'(instr_cnt), 4);
        alu(9'h000); alu(9'h000);
        chk("perf_hold_cycles", int'(cycle_cnt), 6);
        clear_inputs(); start = 1; tick();
        chk("perf_clear_cycles", int'(cycle_cnt), 0);
        chk("perf_clear_instrs", int'(instr_cnt), 0);
`endif

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset_check("rand_rst");
            end else begin
                start         = ($urandom_range(0, 9) == 0);
                instr         = ($urandom_range(0, 19) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
                abs_branch    = ($urandom_range(0, 4) == 0);
                rel_branch    = ($urandom_range(0, 3) == 0);
                branch_flag   = 1'($urandom);
                branch_invert = 1'($urandom);
                mem_to_reg    = ($urandom_range(0, 5) == 0);
                zero_flag     = 1'($urandom);
                neg_flag      = 1'($urandom);
                abs_target    = 10'($urandom);
                rel_offset    = 6'($urandom);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the 9-bit-instruction core. Holds the program counter, sequences fetch, evaluates conditional branches from the control decoder's branch fields and the ALU flags, inserts a wait cycle for data-memory loads, and runs the start/done handshake with the testbench. Sits between the instruction ROM and the control decoder; its `commit` output gates every architectural write (register file and data memory).

## Interface
- `PC_WIDTH`, 10, program counter and instruction ROM address width
- `START_ADDR`, 0, address loaded into the PC on each start
- `HALT_INSTR`, 9'h1FF, instruction encoding that ends the program (opcode 111, otherwise unused)
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin program; sampled in IDLE or HALTED only
- `instr`  in  9  instruction at `pc`, combinational ROM read
- `abs_branch`, `rel_branch`, `branch_flag`, `branch_invert`  in  1 each  decoder branch fields for `instr`
- `mem_to_reg`  in  1  decoder: current instruction is a load
- `zero_flag`, `neg_flag`  in  1 each  ALU flags for the current instruction, same cycle
- `abs_target`  in  PC_WIDTH  absolute target from branch LUT (indexed by instr[5:3])
- `rel_offset`  in  6  signed relative branch offset
- `pc`  out  PC_WIDTH  registered program counter
- `commit`  out  1  current instruction's writes permitted this cycle
- `done`  out  1  registered; program halted

## Operation
- States: IDLE, RUN, LOAD_WAIT, HALTED.
- IDLE: `commit`=0; `start`=1 -> RUN, `pc`<=START_ADDR.
- RUN, `instr`==HALT_INSTR: `commit`=0, `pc` held, -> HALTED, `done`<=1. Halt outranks branch/load decode.
- RUN, `mem_to_reg`=1: `commit`=0, `pc` held, -> LOAD_WAIT.
- RUN, otherwise: `commit`=1; flag = `branch_flag` ? `neg_flag` : `zero_flag`; taken = (`abs_branch`|`rel_branch`) & (flag ^ `branch_invert`).
  - taken & `abs_branch`: `pc`<=`abs_target` (abs has priority if both asserted).
  - taken & `rel_branch`: `pc`<=`pc`+sext(`rel_offset`), modulo 2^PC_WIDTH.
  - else `pc`<=`pc`+1, wrapping max->0.
- LOAD_WAIT: `commit`=1, `pc`<=`pc`+1, -> RUN. Loads never branch.
- HALTED: `done`=1 held, `pc` held; `start`=1 -> RUN, `pc`<=START_ADDR, `done`<=0.
- `start` ignored in RUN and LOAD_WAIT.

## Timing
- Reset (async assert, sync release): state IDLE, `pc`=0, `done`=0, `commit`=0.
- `commit` combinational from state, `instr`, `mem_to_reg`; all other outputs registered.
- Non-load instruction: 1 cycle; load: 2 cycles (write in second); taken branch: 1 cycle, no bubble.
- `done` rises the cycle after the halt instruction is presented; falls the cycle after restart `start`.
- `reset_n` low mid-program aborts immediately; `commit` drops combinationally.

## Configuration
- `PC_PERF_CNT_EN` defined: adds outputs `cycle_cnt` (16) and `instr_cnt` (16). `cycle_cnt` increments every cycle in RUN or LOAD_WAIT; `instr_cnt` increments on each cycle with `commit`=1. Both saturate at 16'hFFFF, clear on accepted `start` and on reset, hold in HALTED.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then `start` pulse with ROM 0:ADD,1:XOR,2:HALT -> `pc` 0,1,2; `commit` 1,1,0; `done`=1 one cycle after pc=2; total run 3 cycles.
- Load at pc 4 -> `pc` stays 4 for 2 cycles, `commit` 0 then 1, then `pc`=5.
- Rel branch at pc 10, `rel_offset`=-3, `branch_flag`=0, `zero_flag`=1, invert 0 -> `pc`=7; same with `branch_invert`=1 -> `pc`=11.
- Abs branch, `branch_flag`=1, `neg_flag`=1, `abs_target`=0x3F0 -> `pc`=0x3F0; rel offset +31 at pc 0x3F0 -> wraps to 0x00F.
- `reset_n` low while in LOAD_WAIT -> `pc`=0, `commit`=0, `done`=0 immediately; `start` while RUN -> ignored.
- With `PC_PERF_CNT_EN`: program of 3 ALU ops, 1 load, halt -> `cycle_cnt`=6, `instr_cnt`=4, held in HALTED, cleared on restart.
